// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: ALU opcodes, shift types, NZCV bit
// positions and the EXE/MEM pipeline register layout.
package arm_pkg;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic [31:0] alu_res;
        logic [31:0] st_val;
        logic [3:0]  dest;
    } exe_mem_t;

    // Rotate right via a doubled word so a zero amount needs no special case.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/val2_gen.sv
// Second ALU operand: rotated 8-bit immediate, 12-bit memory offset, or
// shifted register value.
module val2_gen
    import arm_pkg::*;
(
    input  logic        imm_i,
    input  logic        mem_en_i,
    input  logic [31:0] rm_i,
    input  logic [11:0] shifter_i,
    output logic [31:0] val2_o
);

    logic [4:0]  shamt;
    shift_e      sh_type;
    logic [31:0] shifted;

    assign shamt   = shifter_i[11:7];
    assign sh_type = shift_e'(shifter_i[6:5]);

    always_comb begin
        shifted = rm_i;
        case (sh_type)
            SH_LSL:  shifted = rm_i << shamt;
            SH_LSR:  shifted = rm_i >> shamt;
            SH_ASR:  shifted = $unsigned($signed(rm_i) >>> shamt);
            SH_ROR:  shifted = ror32(rm_i, shamt);
            default: shifted = rm_i;
        endcase

        // Memory offset wins over the register shift when not an immediate.
        if (imm_i)
            val2_o = ror32({24'b0, shifter_i[7:0]}, {shifter_i[11:8], 1'b0});
        else if (mem_en_i)
            val2_o = {20'b0, shifter_i};
        else
            val2_o = shifted;
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: ALU with NZCV generation, status register, branch target
// computation and the EXE/MEM pipeline register.
module exe_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN_EXE,
    input  logic        MEM_R_EN_EXE,
    input  logic        MEM_W_EN_EXE,
    input  logic        S_EXE,
    input  logic        B_EXE,
    input  logic        imm_EXE,
    input  logic [3:0]  exe_cmd_EXE,
    input  logic [31:0] pc_EXE,
    input  logic [31:0] rn_val_EXE,
    input  logic [31:0] rm_val_EXE,
    input  logic [11:0] shifter_operand_EXE,
    input  logic [23:0] signed_imm_24_EXE,
    input  logic [3:0]  dest_EXE,
    input  logic [3:0]  status_EXE,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status_out,
    output logic        WB_EN_MEM,
    output logic        MEM_R_EN_MEM,
    output logic        MEM_W_EN_MEM,
    output logic [31:0] alu_res_MEM,
    output logic [31:0] st_val_MEM,
    output logic [3:0]  dest_MEM
);

    exe_cmd_e    cmd;
    logic [31:0] val2;
    logic        is_sub;
    logic        arith;
    logic        cin;
    logic [31:0] op_b;
    logic [32:0] sum;
    logic [31:0] res;
    logic [3:0]  flags;

    exe_mem_t    exe_mem_d, exe_mem_q;
    logic [3:0]  status_d, status_q;

    assign cmd = exe_cmd_e'(exe_cmd_EXE);

    val2_gen u_val2_gen (
        .imm_i     (imm_EXE),
        .mem_en_i  (MEM_R_EN_EXE | MEM_W_EN_EXE),
        .rm_i      (rm_val_EXE),
        .shifter_i (shifter_operand_EXE),
        .val2_o    (val2)
    );

    // Subtract is rn + ~val2 + cin, so the adder carry-out is already NOT borrow.
    always_comb begin
        is_sub = (cmd == EXE_SUB) || (cmd == EXE_SBC);
        op_b   = is_sub ? ~val2 : val2;
        case (cmd)
            EXE_ADC, EXE_SBC: cin = status_EXE[FLAG_C];
            EXE_SUB:          cin = 1'b1;
            default:          cin = 1'b0;
        endcase
        sum = {1'b0, rn_val_EXE} + {1'b0, op_b} + {32'b0, cin};

        res   = '0;
        arith = 1'b0;
        case (cmd)
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
                res   = sum[31:0];
                arith = 1'b1;
            end
            EXE_AND: res = rn_val_EXE & val2;
            EXE_ORR: res = rn_val_EXE | val2;
            EXE_EOR: res = rn_val_EXE ^ val2;
            default: res = '0;
        endcase

        flags[FLAG_N] = res[31];
        flags[FLAG_Z] = (res == 32'd0);
        flags[FLAG_C] = arith ? sum[32] : status_EXE[FLAG_C];
        flags[FLAG_V] = arith ? ((rn_val_EXE[31] == op_b[31]) && (res[31] != rn_val_EXE[31]))
                              : status_EXE[FLAG_V];
    end

    assign branch_taken = B_EXE;
    assign branch_addr  = pc_EXE + {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};

    always_comb begin
        exe_mem_d = exe_mem_q;
        status_d  = status_q;
        if (!freeze) begin
            exe_mem_d.wb_en    = WB_EN_EXE;
            exe_mem_d.mem_r_en = MEM_R_EN_EXE;
            exe_mem_d.mem_w_en = MEM_W_EN_EXE;
            exe_mem_d.alu_res  = res;
            exe_mem_d.st_val   = rm_val_EXE;
            exe_mem_d.dest     = dest_EXE;
            if (S_EXE)
                status_d = flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_mem_q <= '0;
            status_q  <= '0;
        end else begin
            exe_mem_q <= exe_mem_d;
            status_q  <= status_d;
        end
    end

    assign status_out   = status_q;
    assign WB_EN_MEM    = exe_mem_q.wb_en;
    assign MEM_R_EN_MEM = exe_mem_q.mem_r_en;
    assign MEM_W_EN_MEM = exe_mem_q.mem_w_en;
    assign alu_res_MEM  = exe_mem_q.alu_res;
    assign st_val_MEM   = exe_mem_q.st_val;
    assign dest_MEM     = exe_mem_q.dest;

endmodule

// File: tb/tb_exe_stage.sv
// Directed vector bench for exe_stage: ALU/flag table plus branch, freeze
// and reset sequences.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE, imm_EXE;
    logic [3:0]  exe_cmd_EXE;
    logic [31:0] pc_EXE, rn_val_EXE, rm_val_EXE;
    logic [11:0] shifter_operand_EXE;
    logic [23:0] signed_imm_24_EXE;
    logic [3:0]  dest_EXE, status_EXE;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_out;
    logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
    logic [31:0] alu_res_MEM, st_val_MEM;
    logic [3:0]  dest_MEM;

    int tests = 0;
    int fails = 0;

    exe_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .freeze              (freeze),
        .WB_EN_EXE           (WB_EN_EXE),
        .MEM_R_EN_EXE        (MEM_R_EN_EXE),
        .MEM_W_EN_EXE        (MEM_W_EN_EXE),
        .S_EXE               (S_EXE),
        .B_EXE               (B_EXE),
        .imm_EXE             (imm_EXE),
        .exe_cmd_EXE         (exe_cmd_EXE),
        .pc_EXE              (pc_EXE),
        .rn_val_EXE          (rn_val_EXE),
        .rm_val_EXE          (rm_val_EXE),
        .shifter_operand_EXE (shifter_operand_EXE),
        .signed_imm_24_EXE   (signed_imm_24_EXE),
        .dest_EXE            (dest_EXE),
        .status_EXE          (status_EXE),
        .branch_taken        (branch_taken),
        .branch_addr         (branch_addr),
        .status_out          (status_out),
        .WB_EN_MEM           (WB_EN_MEM),
        .MEM_R_EN_MEM        (MEM_R_EN_MEM),
        .MEM_W_EN_MEM        (MEM_W_EN_MEM),
        .alu_res_MEM         (alu_res_MEM),
        .st_val_MEM          (st_val_MEM),
        .dest_MEM            (dest_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic        imm, mr, mw, s;
        logic [31:0] rn, rm;
        logic [11:0] sh;
        logic [3:0]  st_in;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [3:0] cmd, input logic imm, input logic mr,
                               input logic mw, input logic s, input logic [31:0] rn,
                               input logic [31:0] rm, input logic [11:0] sh,
                               input logic [3:0] st_in, input logic [31:0] exp_res,
                               input logic [3:0] exp_st);
        vec_t t;
        t.cmd = cmd; t.imm = imm; t.mr = mr; t.mw = mw; t.s = s;
        t.rn = rn; t.rm = rm; t.sh = sh; t.st_in = st_in;
        t.exp_res = exp_res; t.exp_st = exp_st;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic imm, input logic mr, input logic mw,
                         input logic s, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] sh, input logic [3:0] st_in, input logic [3:0] dest);
        exe_cmd_EXE = cmd; imm_EXE = imm; MEM_R_EN_EXE = mr; MEM_W_EN_EXE = mw;
        WB_EN_EXE = ~mw; S_EXE = s; rn_val_EXE = rn; rm_val_EXE = rm;
        shifter_operand_EXE = sh; status_EXE = st_in; dest_EXE = dest;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] res, input logic [31:0] st_val,
                           input logic [3:0] dest, input logic [2:0] ctrl, input logic [3:0] st);
        chk({tag, ".alu_res"}, alu_res_MEM, res);
        chk({tag, ".st_val"}, st_val_MEM, st_val);
        chk({tag, ".dest"}, {28'b0, dest_MEM}, {28'b0, dest});
        chk({tag, ".ctrl"}, {29'b0, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM}, {29'b0, ctrl});
        chk({tag, ".status"}, {28'b0, status_out}, {28'b0, st});
    endtask

    logic [3:0] cur_st;

    initial begin
        vecs.push_back(v(4'b0010,1,0,0,1, 32'h7FFFFFFF, 32'h0,        12'h001, 4'b0000, 32'h80000000, 4'b1001));
        vecs.push_back(v(4'b0100,1,0,0,1, 32'h5,        32'h0,        12'h005, 4'b0000, 32'h0,        4'b0110));
        vecs.push_back(v(4'b0100,1,0,0,0, 32'h5,        32'h0,        12'h005, 4'b1111, 32'h0,        4'b0000));
        vecs.push_back(v(4'b0001,1,0,0,1, 32'h0,        32'h0,        12'h4FF, 4'b0011, 32'hFF000000, 4'b1011));
        vecs.push_back(v(4'b0001,0,0,0,0, 32'h0,        32'h80000000, 12'h240, 4'b0000, 32'hF8000000, 4'b0000));
        vecs.push_back(v(4'b1001,1,0,0,1, 32'h0,        32'h0,        12'h000, 4'b0000, 32'hFFFFFFFF, 4'b1000));
        vecs.push_back(v(4'b0011,1,0,0,1, 32'hFFFFFFFF, 32'h0,        12'h000, 4'b0010, 32'h0,        4'b0110));
        vecs.push_back(v(4'b0101,1,0,0,1, 32'hA,        32'h0,        12'h003, 4'b0000, 32'h6,        4'b0010));
        vecs.push_back(v(4'b0110,0,0,0,1, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 4'b0001, 32'hF000F000, 4'b1001));
        vecs.push_back(v(4'b0111,1,0,0,0, 32'h0F,       32'h0,        12'h0F0, 4'b0000, 32'hFF,       4'b0000));
        vecs.push_back(v(4'b1000,0,0,0,0, 32'hFF,       32'h0F,       12'h200, 4'b0000, 32'h0F,       4'b0000));
        vecs.push_back(v(4'b0001,0,0,0,0, 32'h0,        32'h80000000, 12'hFA0, 4'b0000, 32'h1,        4'b0000));
        vecs.push_back(v(4'b0001,0,0,0,0, 32'h0,        32'hF1,       12'h260, 4'b0000, 32'h1000000F, 4'b0000));
        vecs.push_back(v(4'b0001,0,0,0,0, 32'h0,        32'hF1,       12'h270, 4'b0000, 32'h1000000F, 4'b0000));
        vecs.push_back(v(4'b0000,1,0,0,1, 32'h5,        32'h0,        12'h0FF, 4'b1111, 32'h0,        4'b0111));
        vecs.push_back(v(4'b0010,0,0,1,0, 32'h1000,     32'hDEADBEEF, 12'h004, 4'b0000, 32'h1004,     4'b0000));
        vecs.push_back(v(4'b0010,0,1,0,0, 32'h0,        32'h1,        12'hFFF, 4'b0000, 32'hFFF,      4'b0000));
        vecs.push_back(v(4'b0100,1,0,0,1, 32'h80000000, 32'h0,        12'h001, 4'b0000, 32'h7FFFFFFF, 4'b0011));
        vecs.push_back(v(4'b0100,1,0,0,1, 32'h0,        32'h0,        12'h001, 4'b0000, 32'hFFFFFFFF, 4'b1000));
        vecs.push_back(v(4'b0011,1,0,0,1, 32'h1,        32'h0,        12'h001, 4'b0010, 32'h3,        4'b0000));
        vecs.push_back(v(4'b0001,0,0,0,0, 32'h0,        32'h1,        12'h780, 4'b0000, 32'h8000,     4'b0000));
        vecs.push_back(v(4'b0101,1,0,0,1, 32'hA,        32'h0,        12'h003, 4'b0010, 32'h7,        4'b0010));

        rst = 1'b1; freeze = 1'b0; B_EXE = 1'b0; pc_EXE = '0; signed_imm_24_EXE = '0;
        drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h5678, 12'h001, 4'b1111, 4'd9);
        step();
        step();
        chk_all("reset", 32'h0, 32'h0, 4'd0, 3'b000, 4'b0000);

        // Branch target is combinational: check without an edge.
        B_EXE = 1'b1; pc_EXE = 32'h100; signed_imm_24_EXE = 24'hFFFFFE;
        #1;
        chk("br.taken", {31'b0, branch_taken}, 32'h1);
        chk("br.back", branch_addr, 32'hF8);
        pc_EXE = 32'hFFFFFFFC; signed_imm_24_EXE = 24'h000001;
        #1;
        chk("br.wrap", branch_addr, 32'h0);
        B_EXE = 1'b0;
        #1;
        chk("br.not_taken", {31'b0, branch_taken}, 32'h0);

        rst = 1'b0;
        cur_st = 4'b0000;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cmd, vecs[i].imm, vecs[i].mr, vecs[i].mw, vecs[i].s,
                  vecs[i].rn, vecs[i].rm, vecs[i].sh, vecs[i].st_in, 4'(i));
            step();
            if (vecs[i].s) cur_st = vecs[i].exp_st;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].rm, 4'(i),
                    {~vecs[i].mw, vecs[i].mr, vecs[i].mw}, cur_st);
        end

        // Freeze holds everything, even with S and B asserted.
        drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 32'hCAFE, 12'h001, 4'b0000, 4'd5);
        step();
        chk_all("frz.load", 32'h80000000, 32'hCAFE, 4'd5, 3'b100, 4'b1001);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 1'b1, 1'(k == 1), 1'(k == 2), 1'b1, 32'h5 + 32'(k), 32'h1111 * 32'(k + 1),
                  12'h005, 4'b1111, 4'(10 + k));
            B_EXE = 1'b1;
            step();
            chk_all($sformatf("frz%0d", k), 32'h80000000, 32'hCAFE, 4'd5, 3'b100, 4'b1001);
        end
        B_EXE = 1'b0;
        rst = 1'b1;
        step();
        chk_all("frz.rst", 32'h0, 32'h0, 4'd0, 3'b000, 4'b0000);
        rst = 1'b0; freeze = 1'b0;

        // Mid-stream reset discards the instruction present at the reset edge.
        drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 12'h004, 4'b0000, 4'd2);
        step();
        chk_all("str", 32'h1004, 32'hDEADBEEF, 4'd2, 3'b001, 4'b0000);
        rst = 1'b1;
        drive(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h77, 12'h0AA, 4'b1111, 4'd7);
        step();
        chk_all("mid.rst", 32'h0, 32'h0, 4'd0, 3'b000, 4'b0000);
        rst = 1'b0;
        drive(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h66, 12'h055, 4'b0011, 4'd3);
        step();
        chk_all("post.rst", 32'h55, 32'h66, 4'd3, 3'b100, 4'b0011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
